// File: rtl/traffic_lane.sv
// One road row of NUM_CARS cars that step together on a level-scaled tick.
// Positions and the frog hit flag are registered; there is no handshake, so consumers sample the outputs at any time.
module traffic_lane #(
  parameter int NUM_CARS    = 3,
  parameter int GRID_W      = 20,
  parameter int X_BITS      = 5,
  parameter int Y_BITS      = 4,
  parameter int LANE_ROW    = 0,
  parameter int SPEED       = 1,
  parameter int DIRECTION   = 1,
  parameter int SPACING     = 7,
  parameter int TICK_PERIOD = 6250000,
  parameter int LEVEL_STEP  = 500000,
  parameter int MIN_PERIOD  = 1250000,
  parameter int TICK_BITS   = 23,
  parameter int LEVEL_BITS  = 3
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_enable,
  input  logic [LEVEL_BITS-1:0]      i_level,
  input  logic [X_BITS-1:0]          i_frog_x,
  input  logic [Y_BITS-1:0]          i_frog_y,
  output logic [NUM_CARS*X_BITS-1:0] o_cars_x,
  output logic                       o_move_pulse,
  output logic                       o_hit
);

  localparam logic [X_BITS:0]    SPD         = (X_BITS+1)'(SPEED);
  localparam logic [X_BITS:0]    LANE_W      = (X_BITS+1)'(GRID_W + 1);
  localparam logic [X_BITS:0]    LAST_COL    = (X_BITS+1)'(GRID_W);
  localparam logic [31:0]        PERIOD_SPAN = 32'(TICK_PERIOD - MIN_PERIOD);
  localparam logic [TICK_BITS-1:0] MIN_P     = TICK_BITS'(MIN_PERIOD);
  localparam logic [Y_BITS-1:0]  ROW         = Y_BITS'(LANE_ROW);

  if (SPEED < 1 || SPEED > GRID_W) begin : g_bad_speed
    $error("traffic_lane: SPEED must be in 1..GRID_W");
  end
  if (MIN_PERIOD < 1) begin : g_bad_min_period
    $error("traffic_lane: MIN_PERIOD must be at least 1");
  end
  if (64'(TICK_PERIOD) >= (64'd1 << TICK_BITS)) begin : g_bad_tick_bits
    $error("traffic_lane: TICK_PERIOD does not fit in TICK_BITS");
  end

  logic [X_BITS-1:0]    cars_x [NUM_CARS];
  logic [TICK_BITS-1:0] tick_cnt;
  logic [TICK_BITS-1:0] period;
  logic [TICK_BITS-1:0] period_last;
  logic [31:0]          level_dec;
  logic                 step;
  logic                 any_match;

  function automatic logic [X_BITS-1:0] reset_x(input int k);
    return X_BITS'((k * SPACING) % (GRID_W + 1));
  endfunction

  // One extra bit keeps x+SPEED and x+N-SPEED from overflowing before the wrap.
  function automatic logic [X_BITS-1:0] next_x(input logic [X_BITS-1:0] x);
    logic [X_BITS:0] wide;
    logic [X_BITS:0] res;
    wide = {1'b0, x};
    if (DIRECTION == 1) begin
      res = wide + SPD;
      if (res > LAST_COL) res = res - LANE_W;
    end else begin
      if (wide < SPD) res = wide + LANE_W - SPD;
      else            res = wide - SPD;
    end
    return res[X_BITS-1:0];
  endfunction

  always_comb begin
    level_dec = 32'(i_level) * 32'(LEVEL_STEP);
    if (level_dec >= PERIOD_SPAN) period = MIN_P;
    else                          period = TICK_BITS'(32'(TICK_PERIOD) - level_dec);
    period_last = period - TICK_BITS'(1);
    // >= lets a level increase that overshoots the new period fire immediately.
    step = i_enable && (tick_cnt >= period_last);
  end

  always_comb begin
    any_match = 1'b0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (cars_x[k] == i_frog_x) any_match = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      tick_cnt     <= '0;
      o_move_pulse <= 1'b0;
      o_hit        <= 1'b0;
      for (int k = 0; k < NUM_CARS; k++) cars_x[k] <= reset_x(k);
    end else begin
      o_hit        <= (i_frog_y == ROW) && any_match;
      o_move_pulse <= step;
      if (step) begin
        tick_cnt <= '0;
        for (int k = 0; k < NUM_CARS; k++) cars_x[k] <= next_x(cars_x[k]);
      end else if (i_enable) begin
        tick_cnt <= tick_cnt + TICK_BITS'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
    assign o_cars_x[g*X_BITS +: X_BITS] = cars_x[g];
  end

endmodule

// File: doc/traffic_lane.md
Name: traffic_lane

Overview:
- Parametrised successor to the single-car mover; drives NUM_CARS cars sharing one road row of the frogger playfield.
- Provides level-dependent speed, pause, correct modular wrap for any SPEED, and registered frog-collision detection.
- Sits between the game-state controller (enable, level, frog position) and the sprite renderer and collision logic (car x positions, hit flag).
- One instance per road row.

Parameters:
- NUM_CARS, 3, number of cars in the lane (1..8).
- GRID_W, 20, highest column index; columns run 0..GRID_W.
- X_BITS, 5, width of one x coordinate; must satisfy 2^X_BITS > GRID_W.
- Y_BITS, 4, width of row coordinate.
- LANE_ROW, 0, row index this lane occupies.
- SPEED, 1, columns moved per step (1..GRID_W).
- DIRECTION, 1, 1 = increasing x, 0 = decreasing x.
- SPACING, 7, column offset between consecutive cars at reset.
- TICK_PERIOD, 6250000, clock cycles per step at level 0.
- LEVEL_STEP, 500000, cycles removed from the period per level.
- MIN_PERIOD, 1250000, floor on the effective period.
- TICK_BITS, 23, counter width; must hold TICK_PERIOD.
- LEVEL_BITS, 3, width of the level input.

Ports:
- i_Clk  input  1  system clock, 25 MHz.
- i_Rst_n  input  1  synchronous active-low reset.
- i_enable  input  1  1 = lane runs, 0 = paused.
- i_level  input  LEVEL_BITS  current difficulty level.
- i_frog_x  input  X_BITS  frog column.
- i_frog_y  input  Y_BITS  frog row.
- o_cars_x  output  NUM_CARS*X_BITS  packed car columns; car k occupies bits [k*X_BITS +: X_BITS].
- o_move_pulse  output  1  one-cycle strobe on every step.
- o_hit  output  1  frog overlaps a car in this lane.

Behaviour:
- All state changes on posedge i_Clk. Reset is sampled only on the clock edge.
- Reset (i_Rst_n = 0):
  - car k x = (k*SPACING) mod (GRID_W+1);
  - tick counter = 0;
  - o_move_pulse = 0;
  - o_hit = 0.
  - Reset asserted mid-count or mid-step overrides everything in that cycle.
- Effective period P:
  - P = TICK_PERIOD - i_level*LEVEL_STEP, clamped to a minimum of MIN_PERIOD.
  - Compute without underflow: if i_level*LEVEL_STEP >= TICK_PERIOD - MIN_PERIOD, then P = MIN_PERIOD.
  - P is recomputed combinationally every cycle.
- Tick counter:
  - When i_enable = 1 and counter >= P-1: counter <= 0, o_move_pulse <= 1, and all cars step on that same edge.
  - When i_enable = 1 and counter < P-1: counter increments; o_move_pulse <= 0.
  - When i_enable = 0: counter and positions hold; o_move_pulse <= 0.
  - The >= comparison is required: if the level rises mid-count so that the counter already exceeds the new P-1, the step fires on the next enabled cycle.
- Step arithmetic (per car, all cars in parallel), with N = GRID_W+1:
  - DIRECTION = 1: x <= (x + SPEED > GRID_W) ? x + SPEED - N : x + SPEED.
  - DIRECTION = 0: x <= (x < SPEED) ? x + N - SPEED : x - SPEED.
  - Intermediate sums use X_BITS+1 bits. Positions never leave 0..GRID_W.
- Hit detection:
  - o_hit <= (i_frog_y == LANE_ROW) and (any car x == i_frog_x).
  - Evaluated every cycle, including while paused, using the current registered positions.
  - Latency is 1 cycle from a position or frog change to o_hit.
  - On the step edge, o_hit reflects pre-step positions; it updates one cycle later.
- Elaboration checks (simulation-only assertions): SPEED in 1..GRID_W; MIN_PERIOD >= 1; TICK_PERIOD fits in TICK_BITS.
- No other state: there is no FSM beyond the counter, and no handshake. Consumers sample o_cars_x at any time.

Test Plan:
- Reset, defaults except TICK_PERIOD = 4, MIN_PERIOD = 1, LEVEL_STEP = 1 -> o_cars_x = {14,7,0}, o_hit = 0, o_move_pulse = 0.
- Hold i_enable = 1, level 0, for 12 cycles -> o_move_pulse high on cycles 4, 8, 12; cars {15,8,1}, then {16,9,2}, then {17,10,3}.
- Wrap: DIRECTION = 1, SPEED = 3, car at 19 -> next step 1. DIRECTION = 0, SPEED = 3, car at 1 -> 19. DIRECTION = 1, SPEED = 1, car at 20 -> 0.
- Pause: i_enable = 0 with counter at 2 for 10 cycles -> positions and counter frozen, no pulse. Re-enable -> pulse exactly 2 enabled cycles later.
- Level: i_level = 2 while counter = 3 (P becomes 2) -> step on the next enabled cycle. i_level = 7 -> P clamped to MIN_PERIOD = 1, pulse every cycle.
- Hit and reset: i_frog_y = LANE_ROW, i_frog_x = 7 -> o_hit = 1 one cycle later. i_frog_y = LANE_ROW+1 -> o_hit = 0. Assert i_Rst_n = 0 mid-count -> next edge positions {14,7,0}, counter 0, o_hit 0.
